cla_seq_adder: RTL and testbench

- Multi-cycle wide adder built around one `cla_16bit` instance.
- Accepts WIDTH-bit operands through a valid/ready handshake and slices them into 16-bit chunks.
- Feeds one chunk per cycle, LSB chunk first, into `cla_16bit` (`a`, `b`, `carry_start`) and consumes its `sum` and `carry_out`.
- Registers the chunk carry between cycles and presents the full-width result with valid/ready.

---
 rtl/cla_seq_adder.sv | 181 ++++++++++++++++++
 tb/tb_cla_seq_adder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder that feeds one 16-bit carry-lookahead slice per cycle, LSB first.
// Optional subtract mode is enabled by defining CLA_SEQ_ADDER_SUB_EN (adds input port sub).

module cla_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        carry_start,
   output logic [15:0] sum,
   output logic        carry_out
);

   // Carries into bits 0..3 plus the carry out of bit 3, fully expanded (no ripple).
   function automatic logic [4:0] lookahead4(input logic [3:0] g, input logic [3:0] p,
                                             input logic c0);
      logic [4:0] c;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

   logic [15:0] gen;
   logic [15:0] prop;
   logic [3:0]  grp_g;
   logic [3:0]  grp_p;
   logic [4:0]  grp_c;
   logic [4:0]  bit_c;

   assign gen  = a & b;
   assign prop = a ^ b;

   always_comb begin
      grp_g = '0;
      grp_p = '0;
      bit_c = '0;
      sum   = '0;
      for (int j = 0; j < 4; j++) begin
         bit_c    = lookahead4(gen[4*j +: 4], prop[4*j +: 4], 1'b0);
         grp_g[j] = bit_c[4];
         grp_p[j] = &prop[4*j +: 4];
      end
      grp_c = lookahead4(grp_g, grp_p, carry_start);
      for (int j = 0; j < 4; j++) begin
         bit_c            = lookahead4(gen[4*j +: 4], prop[4*j +: 4], grp_c[j]);
         sum[4*j +: 4]    = prop[4*j +: 4] ^ bit_c[3:0];
      end
      carry_out = grp_c[4];
   end

endmodule

module cla_seq_adder #(
   parameter int WIDTH  = 64,
   parameter int NCHUNK = WIDTH / 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CLA_SEQ_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             busy
);

   localparam int K_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [K_W-1:0]   k_q, k_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             sub_i;

   logic [15:0]      cla_a;
   logic [15:0]      cla_b;
   logic [15:0]      cla_sum;
   logic             cla_cout;

`ifdef CLA_SEQ_ADDER_SUB_EN
   assign sub_i = sub;
`else
   assign sub_i = 1'b0;
`endif

   cla_16bit u_cla (
      .a           (cla_a),
      .b           (cla_b),
      .carry_start (carry_q),
      .sum         (cla_sum),
      .carry_out   (cla_cout)
   );

   always_comb begin
      cla_a = '0;
      cla_b = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (k_q == K_W'(i)) begin
            cla_a = a_q[16*i +: 16];
            cla_b = b_q[16*i +: 16];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Subtraction is a + ~b + 1, so the inversion and forced carry happen at capture.
               a_d     = a;
               b_d     = sub_i ? ~b : b;
               carry_d = sub_i ? 1'b1 : cin;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NCHUNK; i++) begin
               if (k_q == K_W'(i)) sum_d[16*i +: 16] = cla_sum;
            end
            carry_d = cla_cout;
            if (k_q == K_W'(NCHUNK - 1)) begin
               cout_d  = cla_cout;
               state_d = DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
      a_q <= a_d;
      b_q <= b_d;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN);
   assign sum       = sum_q;
   assign carry_out = cout_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: a queue holds the expected {carry, sum} of each accepted
// operation and is popped when out_valid is seen.

module tb_cla_seq_adder;

   localparam int W  = 64;
   localparam int NC = W / 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         busy;

   logic [W:0]   sb[$];
   int           vectors = 0;
   int           miscompares = 0;

   cla_seq_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef CLA_SEQ_ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // Applies one operation and waits for its result; leaves the result held when rel=0.
   task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vcin, input logic vsub, input bit rel);
      int lat;
      int busy_cnt;
      logic [W:0] exp;
      if (vsub) exp = {1'b0, va} + {1'b0, ~vb} + (W+1)'(1);
      else      exp = {1'b0, va} + {1'b0, vb} + (W+1)'(vcin);
      check({tag, "_ready"}, {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
      a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
      sb.push_back(exp);
      step();
      in_valid = 1'b0;
      a = rnd64(); b = rnd64(); cin = ~vcin; sub = ~vsub;
      lat = 0;
      busy_cnt = 0;
      while (!out_valid && lat < 20) begin
         if (busy) busy_cnt++;
         step();
         lat++;
      end
      check({tag, "_latency"}, (W+1)'(lat), (W+1)'(NC));
      check({tag, "_busy_cycles"}, (W+1)'(busy_cnt), (W+1)'(NC));
      if (out_valid) begin
         if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, (W+1)'(0), (W+1)'(1));
         end else begin
            exp = sb.pop_front();
            check({tag, "_result"}, {carry_out, sum}, exp);
         end
      end
      if (rel) begin
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check({tag, "_release"}, {{(W-1){1'b0}}, out_valid, in_ready}, (W+1)'(1));
      end
   endtask

   initial begin
      logic [W-1:0] held;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_in_ready", (W+1)'(in_ready), (W+1)'(1));
      check("rst_out_valid", (W+1)'(out_valid), (W+1)'(0));
      check("rst_busy", (W+1)'(busy), (W+1)'(0));
      check("rst_result", {carry_out, sum}, '0);

      // out_ready while idle must not disturb anything
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("idle_out_ready", {{(W-1){1'b0}}, out_valid, in_ready}, (W+1)'(1));

      run_op("basic", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
      run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b1);
      run_op("ripple_b", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
      run_op("chunk_edges", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b1, 1'b0, 1'b1);

      run_op("bp", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0);
      held = sum;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; a = rnd64(); b = rnd64(); cin = 1'b1;
         step();
         in_valid = 1'b0;
         check("bp_hold_sum", {1'b0, sum}, {1'b0, held});
         check("bp_hold_flags", {{(W-2){1'b0}}, out_valid, in_ready, busy}, (W+1)'(3'b100));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_release", {{(W-2){1'b0}}, out_valid, in_ready, busy}, (W+1)'(3'b010));
      check("bp_sb_drained", (W+1)'(sb.size()), (W+1)'(0));

      // reset after two RUN cycles discards the operation
      a = 64'hFFFF; b = 64'h1; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_state", {{(W-2){1'b0}}, out_valid, in_ready, busy}, (W+1)'(3'b010));
      check("midrst_result", {carry_out, sum}, '0);
      for (int i = 0; i < NC + 2; i++) step();
      check("midrst_no_valid", (W+1)'(out_valid), (W+1)'(0));
      run_op("after_rst", 64'h3, 64'h4, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 4; i++) run_op("rand", rnd64(), rnd64(), 1'($urandom()), 1'b0, 1'b1);

`ifdef CLA_SEQ_ADDER_SUB_EN
      run_op("sub_borrow", 64'h5, 64'h7, 1'b0, 1'b1, 1'b1);
      run_op("sub_noborrow", 64'h7, 64'h5, 1'b0, 1'b1, 1'b1);
      run_op("sub_cin_ignored", 64'h7, 64'h7, 1'b1, 1'b1, 1'b1);
      run_op("add_after_sub", 64'h5, 64'h7, 1'b1, 1'b0, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
